// File: rtl/iosys_mem_arb.sv
// iosys_mem_arb: shares one memory port between loader (fixed top priority) and cpu/dma (round-robin),
// with a BUSY-cycle timeout that completes the transaction with 32'hDEAD_BEEF and counts the error.
module iosys_mem_arb #(
  parameter int TIMEOUT = 4096,
  parameter int ADDR_W  = 23
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_wdata,
  input  logic [3:0]        ld_wstrb,
  output logic              ld_ready,
  input  logic              cpu_valid,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_wstrb,
  output logic              cpu_ready,
  output logic [31:0]       cpu_rdata,
  input  logic              dma_valid,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [31:0]       dma_wdata,
  input  logic [3:0]        dma_wstrb,
  output logic              dma_ready,
  output logic [31:0]       dma_rdata,
  output logic              rv_valid,
  input  logic              rv_ready,
  output logic [ADDR_W-1:0] rv_addr,
  output logic [31:0]       rv_wdata,
  output logic [3:0]        rv_wstrb,
  input  logic [31:0]       rv_rdata,
  output logic [1:0]        owner,
  output logic [7:0]        err_cnt
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t            r_state, w_next;
  logic [1:0]        w_gnt, r_owner;
  logic              w_hit, r_to, r_rr, r_valid, r_ld_ready, r_cpu_ready, r_dma_ready;
  logic [CW-1:0]     r_cnt;
  logic [ADDR_W-1:0] w_addr, r_addr;
  logic [31:0]       w_wdata, r_wdata, w_data, r_cpu_rdata, r_dma_rdata;
  logic [3:0]        w_wstrb, r_wstrb;
  logic [7:0]        r_err;
  // r_rr=0 favours cpu, r_rr=1 favours dma on a cpu/dma tie
  always_comb begin
    w_gnt   = ld_valid ? 2'd1 : (cpu_valid && !(dma_valid && r_rr)) ? 2'd2 : dma_valid ? 2'd3 : 2'd0;
    w_addr  = w_gnt == 2'd1 ? ld_addr  : w_gnt == 2'd2 ? cpu_addr  : dma_addr;
    w_wdata = w_gnt == 2'd1 ? ld_wdata : w_gnt == 2'd2 ? cpu_wdata : dma_wdata;
    w_wstrb = w_gnt == 2'd1 ? ld_wstrb : w_gnt == 2'd2 ? cpu_wstrb : dma_wstrb;
    w_hit   = rv_ready || r_to;
    w_data  = rv_ready ? rv_rdata : 32'hDEAD_BEEF;
    w_next  = r_state == IDLE ? (w_gnt != 2'd0 ? BUSY : IDLE) :
              r_state == BUSY ? (w_hit ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end
  // r_to flags the cycle after the counter reaches TIMEOUT-1; rv_ready in that cycle still wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner     <= 2'd0;
      r_valid     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= 32'd0;
      r_wstrb     <= 4'd0;
      r_cnt       <= '0;
      r_to        <= 1'b0;
      r_rr        <= 1'b0;
      r_ld_ready  <= 1'b0;
      r_cpu_ready <= 1'b0;
      r_dma_ready <= 1'b0;
      r_cpu_rdata <= 32'd0;
      r_dma_rdata <= 32'd0;
      r_err       <= 8'd0;
    end else begin
      r_ld_ready  <= 1'b0;
      r_cpu_ready <= 1'b0;
      r_dma_ready <= 1'b0;
      case (r_state)
        IDLE: if (w_gnt != 2'd0) begin
          r_owner <= w_gnt;
          r_valid <= 1'b1;
          r_addr  <= w_addr;
          r_wdata <= w_wdata;
          r_wstrb <= w_wstrb;
          r_cnt   <= '0;
          r_to    <= 1'b0;
          if (w_gnt != 2'd1) r_rr <= w_gnt == 2'd2;
        end
        BUSY: begin
          r_cnt <= r_cnt + CW'(1);
          r_to  <= r_cnt == CW'(TIMEOUT - 1);
          if (w_hit) begin
            r_valid     <= 1'b0;
            r_ld_ready  <= r_owner == 2'd1;
            r_cpu_ready <= r_owner == 2'd2;
            r_dma_ready <= r_owner == 2'd3;
            if (r_owner == 2'd2) r_cpu_rdata <= w_data;
            if (r_owner == 2'd3) r_dma_rdata <= w_data;
            if (!rv_ready && r_err != 8'hFF) r_err <= r_err + 8'd1;
          end
        end
        default: r_owner <= 2'd0;
      endcase
    end
  end
  assign ld_ready  = r_ld_ready;
  assign cpu_ready = r_cpu_ready;
  assign dma_ready = r_dma_ready;
  assign cpu_rdata = r_cpu_rdata;
  assign dma_rdata = r_dma_rdata;
  assign rv_valid  = r_valid;
  assign rv_addr   = r_addr;
  assign rv_wdata  = r_wdata;
  assign rv_wstrb  = r_wstrb;
  assign owner     = r_owner;
  assign err_cnt   = r_err;
endmodule

// File: tb/tb_iosys_mem_arb.sv
// tb_iosys_mem_arb: scoreboard bench for iosys_mem_arb with a latency-programmable memory model.
module tb_iosys_mem_arb;
  logic clk = 1'b0, reset = 1'b1;
  logic ld_valid = 0, cpu_valid = 0, dma_valid = 0;
  logic [22:0] ld_addr = 0, cpu_addr = 0, dma_addr = 0;
  logic [31:0] ld_wdata = 0, cpu_wdata = 0, dma_wdata = 0;
  logic [3:0] ld_wstrb = 0, cpu_wstrb = 0, dma_wstrb = 0;
  logic ld_ready, cpu_ready, dma_ready, rv_valid, rv_ready = 0;
  logic [31:0] cpu_rdata, dma_rdata, rv_wdata, rv_rdata;
  logic [22:0] rv_addr;
  logic [3:0] rv_wstrb;
  logic [1:0] owner;
  logic [7:0] err_cnt;
  int tests = 0, fails = 0;
  int mem_lat = 1, bc = 0;
  bit unstable = 0, pv = 0;
  logic [58:0] pf = 0;
  typedef struct { int port; logic [31:0] data; } exp_t;
  exp_t exp_q[$];

  iosys_mem_arb #(.TIMEOUT(16), .ADDR_W(23)) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_wstrb(ld_wstrb), .ld_ready(ld_ready),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .dma_valid(dma_valid), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_wstrb(dma_wstrb),
    .dma_ready(dma_ready), .dma_rdata(dma_rdata),
    .rv_valid(rv_valid), .rv_ready(rv_ready), .rv_addr(rv_addr), .rv_wdata(rv_wdata),
    .rv_wstrb(rv_wstrb), .rv_rdata(rv_rdata), .owner(owner), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [22:0] a);
    mdata = (a == 23'h100) ? 32'h1234_5678 : ({a[15:0], 16'h5A00} ^ 32'h0F0F_0000);
  endfunction
  assign rv_rdata = mdata(rv_addr);

  // memory: rv_ready in the (mem_lat)-th BUSY cycle counted from 0; mem_lat<0 never answers
  always @(posedge clk) begin
    #1;
    if (!rv_valid) begin bc = 0; rv_ready = 1'b0; end
    else begin rv_ready = (mem_lat >= 0 && bc == mem_lat); bc++; end
  end

  always @(negedge clk) begin
    if (rv_valid && pv && {rv_addr, rv_wdata, rv_wstrb} != pf) unstable = 1;
    pv = rv_valid;
    pf = {rv_addr, rv_wdata, rv_wstrb};
  end

  function automatic logic rdy(input int p);
    rdy = p == 1 ? ld_ready : p == 2 ? cpu_ready : dma_ready;
  endfunction

  task automatic set_req(input int p, input logic v, input logic [22:0] a, input logic [31:0] d, input logic [3:0] s);
    case (p)
      1: begin ld_valid = v; ld_addr = a; ld_wdata = d; ld_wstrb = s; end
      2: begin cpu_valid = v; cpu_addr = a; cpu_wdata = d; cpu_wstrb = s; end
      default: begin dma_valid = v; dma_addr = a; dma_wdata = d; dma_wstrb = s; end
    endcase
  endtask

  task automatic drive(input int p, input logic [22:0] a, input logic [31:0] d, input logic [3:0] s, input int n);
    int t;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      set_req(p, 1'b1, a + 23'(k), d + k, s);
      t = 0;
      do begin @(negedge clk); t++; end while (!rdy(p) && t < 200);
      @(posedge clk); #1;
      set_req(p, 1'b0, a + 23'(k), d + k, s);
    end
  endtask

  task automatic wait_ready(input int budget, output logic [2:0] v, output int t);
    t = 0; v = 3'b000;
    while (v == 3'b000 && t < budget) begin
      @(negedge clk); t++;
      v = {dma_ready, cpu_ready, ld_ready};
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_req(1, 0, 0, 0, 0); set_req(2, 0, 0, 0, 0); set_req(3, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if ({rv_valid, ld_ready, cpu_ready, dma_ready} !== 4'b0) begin fails++;
      $display("FAIL rst_ctl: got %b want 0000", {rv_valid, ld_ready, cpu_ready, dma_ready}); end
    tests++; if ({rv_addr, rv_wdata, rv_wstrb} !== 59'd0) begin fails++;
      $display("FAIL rst_rv: got %h want 0", {rv_addr, rv_wdata, rv_wstrb}); end
    tests++; if ({cpu_rdata, dma_rdata} !== 64'd0) begin fails++;
      $display("FAIL rst_rdata: got %h want 0", {cpu_rdata, dma_rdata}); end
    tests++; if (owner !== 2'd0 || err_cnt !== 8'd0) begin fails++;
      $display("FAIL rst_owner_err: got %0d/%0d want 0/0", owner, err_cnt); end
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (rv_valid !== 1'b0 || owner !== 2'd0) begin fails++;
      $display("FAIL idle_no_req: got rv_valid=%b owner=%0d want 0/0", rv_valid, owner); end
  endtask

  task automatic test_cpu_read();
    logic [2:0] v; int t; exp_t e;
    mem_lat = 3;
    exp_q.push_back('{2, 32'h1234_5678});
    @(posedge clk); #1 set_req(2, 1, 23'h100, 32'h0, 4'h0);
    @(negedge clk);
    tests++; if (rv_valid !== 1'b0) begin fails++; $display("FAIL cpu_rd_early: got rv_valid=%b want 0", rv_valid); end
    @(negedge clk);
    tests++; if (rv_valid !== 1'b1 || owner !== 2'd2) begin fails++;
      $display("FAIL cpu_rd_grant: got rv_valid=%b owner=%0d want 1/2", rv_valid, owner); end
    tests++; if (rv_addr !== 23'h100 || rv_wstrb !== 4'h0) begin fails++;
      $display("FAIL cpu_rd_fields: got addr=%h wstrb=%h want 100/0", rv_addr, rv_wstrb); end
    wait_ready(20, v, t);
    e = exp_q.pop_front();
    tests++; if (v !== 3'b010 || t != 4) begin fails++;
      $display("FAIL cpu_rd_ready: got ready=%b lat=%0d want 010/4", v, t); end
    tests++; if (cpu_rdata !== e.data || owner !== 2'd2) begin fails++;
      $display("FAIL cpu_rd_data: got %h owner=%0d want %h/2", cpu_rdata, owner, e.data); end
    @(posedge clk); #1 set_req(2, 0, 23'h100, 32'h0, 4'h0);
    @(negedge clk);
    tests++; if (cpu_ready !== 1'b0 || owner !== 2'd0) begin fails++;
      $display("FAIL cpu_rd_pulse: got ready=%b owner=%0d want 0/0", cpu_ready, owner); end
    repeat (3) @(negedge clk);
    tests++; if (cpu_rdata !== 32'h1234_5678) begin fails++;
      $display("FAIL cpu_rd_hold: got %h want 12345678", cpu_rdata); end
  endtask

  task automatic test_priority();
    logic [2:0] v, ev; int t, n; exp_t e; logic [31:0] got;
    do_reset();
    mem_lat = 1;
    exp_q.push_back('{1, 32'h0});
    exp_q.push_back('{2, mdata(23'h210)});
    exp_q.push_back('{3, mdata(23'h310)});
    fork
      drive(1, 23'h110, 32'hAAAA_0001, 4'hF, 1);
      drive(2, 23'h210, 32'h0, 4'h0, 1);
      drive(3, 23'h310, 32'h0, 4'h0, 1);
    join_none
    for (int i = 0; i < 3; i++) begin
      wait_ready(60, v, t);
      e = exp_q.pop_front();
      ev = 3'b001 << (e.port - 1);
      tests++; if (v !== ev || owner !== 2'(e.port)) begin fails++;
        $display("FAIL prio_order[%0d]: got ready=%b owner=%0d want %b/%0d", i, v, owner, ev, e.port); end
      got = e.port == 2 ? cpu_rdata : dma_rdata;
      if (e.port != 1) begin
        tests++; if (got !== e.data) begin fails++;
          $display("FAIL prio_data[%0d]: got %h want %h", i, got, e.data); end
      end
    end
    wait fork;
    n = 0;
    repeat (10) begin @(negedge clk); n += int'(ld_ready) + int'(cpu_ready) + int'(dma_ready); end
    tests++; if (n != 0) begin fails++; $display("FAIL prio_extra: got %0d extra readies want 0", n); end
  endtask

  task automatic test_round_robin();
    logic [2:0] v, ev; int t; exp_t e; logic [31:0] got;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back('{2, mdata(23'h220 + 23'(k))});
      exp_q.push_back('{3, mdata(23'h320 + 23'(k))});
    end
    fork
      drive(2, 23'h220, 32'h0, 4'h0, 3);
      drive(3, 23'h320, 32'h55, 4'h3, 3);
    join_none
    for (int i = 0; i < 6; i++) begin
      wait_ready(60, v, t);
      e = exp_q.pop_front();
      ev = 3'b001 << (e.port - 1);
      got = e.port == 2 ? cpu_rdata : dma_rdata;
      tests++; if (v !== ev || got !== e.data) begin fails++;
        $display("FAIL rr_alt[%0d]: got ready=%b data=%h want %b/%h", i, v, got, ev, e.data); end
    end
    wait fork;
  endtask

  task automatic test_rr_tie();
    logic [2:0] v, ev; int t; exp_t e;
    exp_q.push_back('{2, mdata(23'h230)});
    exp_q.push_back('{3, mdata(23'h330)});
    exp_q.push_back('{2, mdata(23'h231)});
    fork drive(2, 23'h230, 32'h0, 4'h0, 1); join_none
    wait_ready(40, v, t);
    e = exp_q.pop_front();
    tests++; if (v !== 3'b010) begin fails++; $display("FAIL tie_solo: got ready=%b want 010", v); end
    wait fork;
    fork
      drive(2, 23'h231, 32'h0, 4'h0, 1);
      drive(3, 23'h330, 32'h0, 4'h0, 1);
    join_none
    for (int i = 0; i < 2; i++) begin
      wait_ready(60, v, t);
      e = exp_q.pop_front();
      ev = 3'b001 << (e.port - 1);
      tests++; if (v !== ev) begin fails++;
        $display("FAIL tie_order[%0d]: got ready=%b want %b", i, v, ev); end
    end
    wait fork;
  endtask

  task automatic test_drop_ignored();
    logic [2:0] v; int t, n; exp_t e;
    mem_lat = 4;
    exp_q.push_back('{2, mdata(23'h140)});
    @(posedge clk); #1 set_req(2, 1, 23'h140, 32'h0, 4'h0);
    @(posedge clk); #1 set_req(2, 0, 23'h140, 32'h0, 4'h0);
    set_req(3, 1, 23'h340, 32'h0, 4'h0);
    @(posedge clk); #1 set_req(3, 0, 23'h340, 32'h0, 4'h0);
    wait_ready(20, v, t);
    e = exp_q.pop_front();
    tests++; if (v !== 3'b010 || cpu_rdata !== e.data) begin fails++;
      $display("FAIL drop_granted: got ready=%b data=%h want 010/%h", v, cpu_rdata, e.data); end
    n = 0;
    repeat (12) begin @(negedge clk); n += int'(rv_valid) + int'(dma_ready) + int'(owner != 2'd0); end
    tests++; if (n != 0) begin fails++; $display("FAIL drop_ignored: got %0d active cycles want 0", n); end
  endtask

  task automatic test_timeout();
    logic [2:0] v; int t; exp_t e;
    do_reset();
    mem_lat = -1;
    exp_q.push_back('{3, 32'hDEAD_BEEF});
    @(posedge clk); #1 set_req(3, 1, 23'h400, 32'hCAFE_F00D, 4'hF);
    @(negedge clk);
    @(negedge clk);
    tests++; if (rv_valid !== 1'b1 || rv_wdata !== 32'hCAFE_F00D || rv_wstrb !== 4'hF) begin fails++;
      $display("FAIL to_req: got v=%b wdata=%h wstrb=%h want 1/cafef00d/f", rv_valid, rv_wdata, rv_wstrb); end
    unstable = 0;
    wait_ready(40, v, t);
    e = exp_q.pop_front();
    tests++; if (v !== 3'b100 || t != 17) begin fails++;
      $display("FAIL to_lat: got ready=%b lat=%0d want 100/17", v, t); end
    tests++; if (dma_rdata !== e.data || err_cnt !== 8'd1) begin fails++;
      $display("FAIL to_data: got %h err=%0d want %h/1", dma_rdata, err_cnt, e.data); end
    tests++; if (unstable !== 1'b0) begin fails++; $display("FAIL to_stable: got rv fields changing want stable"); end
    @(posedge clk); #1 set_req(3, 0, 23'h400, 32'hCAFE_F00D, 4'hF);
    for (int lat = 15; lat <= 16; lat++) begin
      mem_lat = lat;
      exp_q.push_back('{2, mdata(23'h150 + 23'(lat))});
      @(posedge clk); #1 set_req(2, 1, 23'h150 + 23'(lat), 32'h0, 4'h0);
      @(negedge clk);
      @(negedge clk);
      wait_ready(40, v, t);
      e = exp_q.pop_front();
      tests++; if (v !== 3'b010 || t != lat + 1 || cpu_rdata !== e.data || err_cnt !== 8'd1) begin fails++;
        $display("FAIL to_race[%0d]: got ready=%b lat=%0d data=%h err=%0d want 010/%0d/%h/1",
                 lat, v, t, cpu_rdata, err_cnt, lat + 1, e.data); end
      @(posedge clk); #1 set_req(2, 0, 23'h0, 32'h0, 4'h0);
    end
  endtask

  task automatic test_err_sat();
    logic [2:0] v; int t; exp_t e;
    do_reset();
    mem_lat = -1;
    for (int i = 0; i < 260; i++) begin
      exp_q.push_back('{2, 32'hDEAD_BEEF});
      @(posedge clk); #1 set_req(2, 1, 23'h500, 32'h0, 4'h0);
      wait_ready(40, v, t);
      e = exp_q.pop_front();
      tests++; if (v !== 3'b010 || cpu_rdata !== e.data || err_cnt !== 8'((i + 1 > 255) ? 255 : i + 1)) begin fails++;
        $display("FAIL err_sat[%0d]: got ready=%b data=%h err=%0d want 010/%h/%0d",
                 i, v, cpu_rdata, err_cnt, e.data, (i + 1 > 255) ? 255 : i + 1); end
      @(posedge clk); #1 set_req(2, 0, 23'h500, 32'h0, 4'h0);
    end
    tests++; if (err_cnt !== 8'd255) begin fails++; $display("FAIL err_final: got %0d want 255", err_cnt); end
  endtask

  task automatic test_reset_busy();
    logic [2:0] v; int t, n; exp_t e;
    mem_lat = -1;
    @(posedge clk); #1 set_req(2, 1, 23'h160, 32'h0, 4'h0);
    t = 0;
    do begin @(negedge clk); t++; end while (!rv_valid && t < 10);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    tests++; if (rv_valid !== 1'b0 || owner !== 2'd0 || err_cnt !== 8'd0) begin fails++;
      $display("FAIL rstbusy_async: got v=%b owner=%0d err=%0d want 0/0/0", rv_valid, owner, err_cnt); end
    set_req(2, 0, 23'h160, 32'h0, 4'h0);
    n = 0;
    repeat (2) begin @(negedge clk); n += int'(cpu_ready) + int'(rv_valid); end
    @(posedge clk); #1 reset = 1'b0;
    repeat (10) begin @(negedge clk); n += int'(cpu_ready) + int'(rv_valid) + int'(owner != 2'd0); end
    tests++; if (n != 0) begin fails++; $display("FAIL rstbusy_quiet: got %0d active cycles want 0", n); end
    mem_lat = 2;
    exp_q.push_back('{2, mdata(23'h161)});
    fork drive(2, 23'h161, 32'h0, 4'h0, 1); join_none
    wait_ready(30, v, t);
    e = exp_q.pop_front();
    tests++; if (v !== 3'b010 || cpu_rdata !== e.data) begin fails++;
      $display("FAIL rstbusy_after: got ready=%b data=%h want 010/%h", v, cpu_rdata, e.data); end
    wait fork;
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_priority();
    test_round_robin();
    test_rr_tie();
    test_drop_ignored();
    test_timeout();
    test_err_sat();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/iosys_mem_arb.md
IOSYS_MEM_ARB -- requirements
Module: iosys_mem_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 4096, meaning the number of BUSY cycles without rv_ready before the arbiter forces completion.
REQ-002 SHALL have parameter ADDR_W, default 23, meaning the width of the shared memory address.
REQ-003 clk  in  1  single clock; all logic is clocked on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 ld_valid, ld_addr[ADDR_W-1:0], ld_wdata[31:0], ld_wstrb[3:0]  in  firmware-loader request; write-only, ld_wstrb is never 0.
REQ-006 ld_ready  out  1  one-cycle completion pulse to the loader.
REQ-007 cpu_valid, cpu_addr[ADDR_W-1:0], cpu_wdata[31:0], cpu_wstrb[3:0]  in  softcore request; cpu_wstrb==0 means read.
REQ-008 cpu_ready  out  1  completion pulse to the softcore; cpu_rdata  out  32  read data, valid while cpu_ready=1.
REQ-009 dma_valid, dma_addr[ADDR_W-1:0], dma_wdata[31:0], dma_wstrb[3:0]  in  DMA/ROM-load request; dma_wstrb==0 means read.
REQ-010 dma_ready  out  1  completion pulse to the DMA port; dma_rdata  out  32  read data, valid while dma_ready=1.
REQ-011 rv_valid  out  1  shared memory request, held until accepted; rv_ready  in  1  one-cycle completion from memory.
REQ-012 rv_addr[ADDR_W-1:0], rv_wdata[31:0], rv_wstrb[3:0]  out  shared request fields; rv_rdata  in  32  read data, valid with rv_ready.
REQ-013 owner  out  2  current grant: 0=none, 1=loader, 2=cpu, 3=dma.
REQ-014 err_cnt  out  8  saturating count of timeouts.

Function
REQ-015 SHALL implement the states IDLE, BUSY and DONE.
REQ-016 IDLE: if any *_valid is high, SHALL grant one requester, latch its addr/wdata/wstrb into registers and go to BUSY on the next edge; otherwise it stays in IDLE.
REQ-017 Priority: the loader SHALL always win; cpu and dma are served round-robin, and the one not served most recently wins a tie.
REQ-018 The round-robin pointer SHALL be reset to favour cpu, and SHALL be updated only when cpu or dma is granted.
REQ-019 BUSY: rv_valid=1 with the registered fields; rv_* SHALL stay stable for the whole BUSY period.
REQ-020 BUSY: on rv_ready=1, the arbiter SHALL capture rv_rdata and go to DONE.
REQ-021 BUSY: the timeout counter starts at 0 on entry and increments each cycle.
REQ-022 If the timeout counter reaches TIMEOUT-1 without rv_ready, the arbiter SHALL go to DONE with captured data 32'hDEAD_BEEF and increment err_cnt; err_cnt saturates at 255.
REQ-023 If rv_ready arrives in the same cycle as the timeout, rv_ready SHALL win: real data is returned and err_cnt is unchanged.
REQ-024 DONE: exactly one cycle; only the owner's *_ready=1, its *_rdata equals the captured data, and the next state is IDLE.
REQ-025 Minimum latency: request visible in IDLE at cycle N gives rv_valid=1 at N+1; rv_ready at cycle M gives owner ready at M+1.
REQ-026 Requesters drop valid the cycle after their ready. IDLE samples valids only after DONE, so a completed request is never re-granted.
REQ-027 A requester whose valid drops while it is not granted SHALL be ignored; a granted transaction SHALL complete regardless of the requester's valid.
REQ-028 Each *_rdata SHALL hold its last returned value between transactions.
REQ-029 owner SHALL equal the granted port in BUSY and DONE, and 0 in IDLE.
REQ-030 rv_ready SHALL be ignored outside BUSY.

Reset
REQ-031 While reset=1, asynchronously: state=IDLE, rv_valid=0, rv_addr/rv_wdata/rv_wstrb=0, all *_ready=0, all *_rdata=0, owner=0, err_cnt=0, timeout counter=0, round-robin pointer favours cpu.
REQ-032 Reset asserted mid-transaction SHALL abandon it without a ready pulse; after release the arbiter starts from IDLE.

Verification
REQ-033 cpu read addr 0x000100 with memory rv_ready 3 cycles after rv_valid and rdata 0x12345678 -> rv_valid 1 cycle after cpu_valid; cpu_ready for exactly 1 cycle with cpu_rdata=0x12345678; owner goes 2 then 0.
REQ-034 ld, cpu and dma valid in the same cycle -> grant order ld, cpu, dma; owner sequence 1, 2, 3; each *_ready pulses exactly once.
REQ-035 cpu and dma both continuously re-requesting for 6 transactions -> grants strictly alternate cpu, dma, cpu, dma, cpu, dma.
REQ-036 dma write with no rv_ready, TIMEOUT=16 -> dma_ready 17 cycles after rv_valid rose, dma_rdata=0xDEADBEEF, err_cnt=1.
REQ-037 260 forced timeouts -> err_cnt=255.
REQ-038 reset pulsed during BUSY -> rv_valid drops immediately and no *_ready pulse occurs; a new cpu request after release completes normally.
